// File: rtl/mi_arb2_if.sv
// Bundle between mi_arb2 and its two requesters plus the shared mi_* slave.
// 'master' is the arbiter's view (it masters the slave); 'slave' is the environment's view.
interface mi_arb2_if #(
    parameter int AW = 24,
    parameter int LW = 7
);
    logic [2*AW-1:0] m_addr;
    logic [2*LW-1:0] m_len;
    logic [1:0]      m_rw;
    logic [1:0]      m_valid;
    logic [1:0]      m_ready;
    logic [63:0]     m_wdata;
    logic [1:0]      m_wack;
    logic [1:0]      m_wlast;
    logic [31:0]     m_rdata;
    logic [1:0]      m_rstb;
    logic [1:0]      m_rlast;

    logic [AW-1:0]   s_addr;
    logic [LW-1:0]   s_len;
    logic            s_rw;
    logic            s_valid;
    logic            s_ready;
    logic [31:0]     s_wdata;
    logic            s_wack;
    logic            s_wlast;
    logic [31:0]     s_rdata;
    logic            s_rstb;
    logic            s_rlast;

    modport master (
        input  m_addr, m_len, m_rw, m_valid, m_wdata,
        input  s_ready, s_wack, s_wlast, s_rdata, s_rstb, s_rlast,
        output m_ready, m_wack, m_wlast, m_rdata, m_rstb, m_rlast,
        output s_addr, s_len, s_rw, s_valid, s_wdata
    );

    modport slave (
        output m_addr, m_len, m_rw, m_valid, m_wdata,
        output s_ready, s_wack, s_wlast, s_rdata, s_rstb, s_rlast,
        input  m_ready, m_wack, m_wlast, m_rdata, m_rstb, m_rlast,
        input  s_addr, s_len, s_rw, s_valid, s_wdata
    );
endinterface

// File: rtl/mi_arb2.sv
// mi_arb2: shares one mi_* slave between two requesters, one whole transaction at a time.
// Round-robin by default; define MI_ARB_FIXED_PRIO_EN to let requester 0 win every tie.
module mi_arb2 #(
    parameter int AW = 24,
    parameter int LW = 7
) (
    input  logic      clk_4x_s,
    input  logic      rst,
    mi_arb2_if.master bus
);
    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic          rw_q, rw_d;
    logic          pick;
    logic          done;
    logic [AW-1:0] addr_sel;
    logic [LW-1:0] len_sel;
    logic [31:0]   wdata_sel;

    assign addr_sel  = gnt_q ? bus.m_addr[2*AW-1:AW] : bus.m_addr[AW-1:0];
    assign len_sel   = gnt_q ? bus.m_len[2*LW-1:LW]  : bus.m_len[LW-1:0];
    assign wdata_sel = gnt_q ? bus.m_wdata[63:32]    : bus.m_wdata[31:0];

    // Only meaningful when at least one m_valid bit is set.
    always_comb begin
`ifdef MI_ARB_FIXED_PRIO_EN
        pick = ~bus.m_valid[0];
`else
        pick = (&bus.m_valid) ? ~last_q : bus.m_valid[1];
`endif
    end

    assign done = rw_q ? (bus.s_rstb & bus.s_rlast) : (bus.s_wack & bus.s_wlast);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        rw_d    = rw_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.m_valid) begin
                    gnt_d   = pick;
                    state_d = CMD;
                end
            end
            CMD: begin
                if (bus.m_valid[gnt_q] && bus.s_ready) begin
                    rw_d    = bus.m_rw[gnt_q];
                    state_d = DATA;
                end else if (!bus.m_valid[gnt_q]) begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (done) begin
                    last_d  = gnt_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_4x_s) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            rw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            rw_q    <= rw_d;
        end
    end

    // Slave strobes are only forwarded while a burst owns the bus.
    always_comb begin
        bus.s_addr  = '0;
        bus.s_len   = '0;
        bus.s_rw    = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_wdata = '0;
        bus.m_ready = '0;
        bus.m_wack  = '0;
        bus.m_wlast = '0;
        bus.m_rstb  = '0;
        bus.m_rlast = '0;
        case (state_q)
            CMD: begin
                bus.s_addr         = addr_sel;
                bus.s_len          = len_sel;
                bus.s_rw           = bus.m_rw[gnt_q];
                bus.s_valid        = bus.m_valid[gnt_q];
                bus.m_ready[gnt_q] = bus.s_ready;
            end
            DATA: begin
                bus.s_wdata        = wdata_sel;
                bus.m_wack[gnt_q]  = bus.s_wack;
                bus.m_wlast[gnt_q] = bus.s_wlast;
                bus.m_rstb[gnt_q]  = bus.s_rstb;
                bus.m_rlast[gnt_q] = bus.s_rlast;
            end
            default: ;
        endcase
    end

    assign bus.m_rdata = bus.s_rdata;
endmodule

// File: tb/tb_mi_arb2.sv
// Bench for mi_arb2: directed vector table, hand-written corner sequences, and a
// randomized run against a transaction-level model of requesters, arbiter and slave.
module tb_mi_arb2;
    localparam int AW = 24;
    localparam int LW = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mi_arb2_if #(.AW(AW), .LW(LW)) bus ();
    mi_arb2 #(.AW(AW), .LW(LW)) dut (.clk_4x_s(clk), .rst(rst), .bus(bus));

    int errs   = 0;
    int checks = 0;

    typedef struct {
        logic [1:0] mv;
        logic       sr;
        logic       rs;
        logic       rl;
        logic [1:0] er;
        logic       es;
        logic [1:0] ers;
        logic [1:0] erl;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        bus.m_addr  = '0;
        bus.m_len   = '0;
        bus.m_rw    = '0;
        bus.m_valid = '0;
        bus.m_wdata = '0;
        bus.s_ready = 1'b0;
        bus.s_wack  = 1'b0;
        bus.s_wlast = 1'b0;
        bus.s_rdata = '0;
        bus.s_rstb  = 1'b0;
        bus.s_rlast = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Returns at mid-cycle with s_valid high, or records a timeout failure.
    task automatic wait_svalid(input string nm);
        int n;
        n = 0;
        #4;
        while (bus.s_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #5;
            n++;
        end
        if (n >= 20) chk(nm, 64'(bus.s_valid), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1);
    end

    initial begin
        vec_t       tv[14];
        logic [1:0] alt_exp[4];

        tv[0]  = '{2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00};
        tv[1]  = '{2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 2'b00};
        tv[2]  = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00};
        tv[3]  = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00};
        tv[4]  = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00};
        tv[5]  = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00};
        tv[6]  = '{2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 2'b01};
        tv[7]  = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00};
        tv[8]  = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00};
        tv[9]  = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00};
        tv[10] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00};
        tv[11] = '{2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 2'b01};
        tv[12] = '{2'b00, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00};
        tv[13] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00};

`ifdef MI_ARB_FIXED_PRIO_EN
        alt_exp[0] = 2'b01; alt_exp[1] = 2'b01; alt_exp[2] = 2'b01; alt_exp[3] = 2'b01;
`else
        alt_exp[0] = 2'b01; alt_exp[1] = 2'b10; alt_exp[2] = 2'b01; alt_exp[3] = 2'b10;
`endif

        // Reset state: junk on every input, outputs must stay quiet.
        clr_in();
        rst = 1'b1;
        bus.m_valid = 2'b11; bus.s_ready = 1'b1; bus.s_rstb = 1'b1; bus.s_rlast = 1'b1;
        bus.s_wack = 1'b1; bus.s_wlast = 1'b1; bus.s_rdata = 32'hDEADBEEF;
        tick();
        tick();
        #4;
        chk("reset_ctl", {bus.m_ready, bus.m_wack, bus.m_wlast, bus.m_rstb, bus.m_rlast, bus.s_valid}, '0);
        chk("reset_rdata", 64'(bus.m_rdata), 64'h0DEADBEEF);
        tick();
        clr_in();

        // Eight-beat read by requester 0 from the vector table.
        do_reset();
        bus.m_addr = {24'h0ABCDE, 24'h000100};
        bus.m_len  = {7'd2, 7'd7};
        bus.m_rw   = 2'b11;
        for (int i = 0; i < 14; i++) begin
            bus.m_valid = tv[i].mv;
            bus.s_ready = tv[i].sr;
            bus.s_rstb  = tv[i].rs;
            bus.s_rlast = tv[i].rl;
            #4;
            chk($sformatf("vec%0d", i), {bus.m_ready, bus.s_valid, bus.m_rstb, bus.m_rlast},
                {tv[i].er, tv[i].es, tv[i].ers, tv[i].erl});
            if (tv[i].es) chk("vec_cmd", {bus.s_addr, bus.s_len, bus.s_rw}, {24'h000100, 7'd7, 1'b1});
            tick();
        end
        clr_in();

        // Both requesters held: single-beat reads, grant order checked.
        do_reset();
        bus.m_valid = 2'b11; bus.m_rw = 2'b11; bus.m_len = '0;
        bus.m_addr = {24'h000200, 24'h000100}; bus.s_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_svalid("alt_wait");
            chk($sformatf("alt_gnt%0d", k), 64'(bus.m_ready), 64'(alt_exp[k]));
            tick();
            bus.s_rstb = 1'b1; bus.s_rlast = 1'b1;
            #4;
            chk($sformatf("alt_beat%0d", k), 64'(bus.m_rstb), 64'(alt_exp[k]));
            tick();
            bus.s_rstb = 1'b0; bus.s_rlast = 1'b0;
        end
        bus.m_valid = 2'b00;

        // Requester 1 write, 4 beats, wack every other cycle.
        bus.m_valid = 2'b10; bus.m_rw = 2'b00; bus.m_len = {7'd3, 7'd0};
        bus.m_addr = {24'hABCDE0, 24'h000000};
        wait_svalid("wr_wait");
        chk("wr_gnt", 64'(bus.m_ready), 64'(2'b10));
        chk("wr_cmd", {bus.s_addr, bus.s_len, bus.s_rw}, {24'hABCDE0, 7'd3, 1'b0});
        tick();
        bus.m_valid = 2'b00;
        for (int c = 0; c < 8; c++) begin
            bus.m_wdata = {$urandom, $urandom};
            bus.s_wack  = c[0];
            bus.s_wlast = (c == 7);
            #4;
            if (bus.s_wack) chk("wr_data", 64'(bus.s_wdata), 64'(bus.m_wdata[63:32]));
            chk("wr_strb", {bus.m_wack, bus.m_wlast}, {bus.s_wack, 1'b0, bus.s_wlast, 1'b0});
            tick();
        end
        bus.s_wack = 1'b1; bus.s_wlast = 1'b1;
        #4;
        chk("wr_exit", {bus.m_wack, bus.m_wlast, bus.s_valid}, '0);
        tick();
        bus.s_wack = 1'b0; bus.s_wlast = 1'b0;

        // Slave stalls the command for 5 cycles while both requesters wait.
        bus.m_valid = 2'b11; bus.m_rw = 2'b11; bus.m_len = '0;
        bus.m_addr = {24'h0000AA, 24'h000055}; bus.s_ready = 1'b0;
        wait_svalid("rdy_wait");
        for (int i = 0; i < 5; i++) begin
            if (i > 0) #4;
            chk("rdy_hold", {bus.m_ready, bus.s_valid, bus.s_addr}, {2'b00, 1'b1, 24'h000055});
            tick();
        end
        bus.s_ready = 1'b1;
        #4;
        chk("rdy_rise", 64'(bus.m_ready), 64'(2'b01));
        tick();
        bus.m_valid = 2'b00; bus.s_rstb = 1'b1; bus.s_rlast = 1'b1;
        #4;
        chk("rdy_beat", {bus.m_rstb, bus.m_rlast}, 4'b0101);
        tick();
        bus.s_rstb = 1'b0; bus.s_rlast = 1'b0;

        // Reset on the 3rd of 8 read beats abandons the burst.
        bus.m_valid = 2'b01; bus.m_rw = 2'b01; bus.m_len = {7'd0, 7'd7};
        bus.m_addr = {24'h000000, 24'h000300}; bus.s_ready = 1'b1;
        bus.m_wdata = {32'h11111111, 32'h22222222};
        wait_svalid("rst_wait");
        tick();
        bus.m_valid = 2'b00;
        for (int b = 1; b <= 3; b++) begin
            bus.s_rstb = 1'b1;
            if (b == 3) rst = 1'b1;
            #4;
            if (b < 3) chk("rst_pre", 64'(bus.m_rstb), 64'(2'b01));
            tick();
        end
        rst = 1'b0;
        bus.s_rdata = 32'h5A5A1234;
        #4;
        chk("rst_ctl", {bus.m_ready, bus.m_wack, bus.m_wlast, bus.m_rstb, bus.m_rlast,
                        bus.s_valid, bus.s_rw, bus.s_len}, '0);
        chk("rst_bus", {bus.s_addr, bus.s_wdata}, '0);
        chk("rst_rdata", 64'(bus.m_rdata), 64'h05A5A1234);
        tick();
        for (int b = 4; b <= 8; b++) begin
            bus.s_rstb = 1'b1; bus.s_rlast = (b == 8);
            #4;
            chk("rst_after", {bus.m_rstb, bus.m_rlast}, '0);
            tick();
        end
        bus.s_rstb = 1'b0; bus.s_rlast = 1'b0;
        bus.m_len = '0; bus.m_valid = 2'b01;
        #4;
        chk("rst_idle", 64'(bus.s_valid), 64'd0);
        tick();
        #4;
        chk("rst_regnt", {bus.m_ready, bus.s_valid}, 3'b011);
        tick();
        bus.m_valid = 2'b00; bus.s_rstb = 1'b1; bus.s_rlast = 1'b1;
        #4;
        chk("rst_done", {bus.m_rstb, bus.m_rlast}, 4'b0101);
        tick();
        clr_in();

        // Randomized run against a transaction-level model.
        begin : rnd
            int            ph;      // 0 waiting for grant, 1 command offered, 2 burst
            int            beats;
            bit            g, lastr, rwm;
            logic [1:0]    mv;
            bit   [1:0]    infl;
            logic [AW-1:0] ra[2];
            logic [LW-1:0] rl[2];
            bit            rrw[2];
            logic [1:0]    e_rdy, e_rs, e_rl, e_wa, e_wl;
            logic          e_sv;

            do_reset();
            ph = 0; beats = 0; g = 1'b0; lastr = 1'b1; rwm = 1'b0; mv = '0; infl = '0;
            for (int i = 0; i < 2; i++) begin
                ra[i] = '0; rl[i] = '0; rrw[i] = 1'b0;
            end
            for (int cyc = 0; cyc < 3000; cyc++) begin
                for (int i = 0; i < 2; i++) begin
                    if (!mv[i] && !infl[i] && $urandom_range(0, 3) == 0) begin
                        mv[i]  = 1'b1;
                        ra[i]  = AW'($urandom);
                        rl[i]  = LW'($urandom_range(0, 3));
                        rrw[i] = 1'($urandom_range(0, 1));
                    end
                end
                bus.m_valid = mv;
                bus.m_addr  = {ra[1], ra[0]};
                bus.m_len   = {rl[1], rl[0]};
                bus.m_rw    = {rrw[1], rrw[0]};
                bus.m_wdata = {$urandom, $urandom};
                bus.s_ready = 1'($urandom_range(0, 1));
                bus.s_rdata = $urandom;
                {bus.s_rstb, bus.s_rlast, bus.s_wack, bus.s_wlast} = 4'($urandom);
                if (ph == 2) begin
                    if (rwm) bus.s_rlast = (beats == 1);
                    else     bus.s_wlast = (beats == 1);
                end
                #4;
                e_rdy = (ph == 1) ? (2'(bus.s_ready) << g) : 2'b00;
                e_sv  = (ph == 1) ? mv[g] : 1'b0;
                e_rs  = (ph == 2) ? (2'(bus.s_rstb)  << g) : 2'b00;
                e_rl  = (ph == 2) ? (2'(bus.s_rlast) << g) : 2'b00;
                e_wa  = (ph == 2) ? (2'(bus.s_wack)  << g) : 2'b00;
                e_wl  = (ph == 2) ? (2'(bus.s_wlast) << g) : 2'b00;
                chk("rnd_ctl", {bus.m_ready, bus.s_valid, bus.m_rstb, bus.m_rlast, bus.m_wack, bus.m_wlast},
                    {e_rdy, e_sv, e_rs, e_rl, e_wa, e_wl});
                chk("rnd_rdata", 64'(bus.m_rdata), 64'(bus.s_rdata));
                if (ph == 1) chk("rnd_cmd", {bus.s_addr, bus.s_len, bus.s_rw}, {ra[g], rl[g], rrw[g]});
                if (ph == 2) chk("rnd_wdata", 64'(bus.s_wdata), g ? 64'(bus.m_wdata[63:32]) : 64'(bus.m_wdata[31:0]));

                case (ph)
                    0: begin
                        if (mv != 2'b00) begin
`ifdef MI_ARB_FIXED_PRIO_EN
                            g = mv[0] ? 1'b0 : 1'b1;
`else
                            // a tie goes to whoever was not served most recently
                            g = (mv == 2'b11) ? ~lastr : mv[1];
`endif
                            ph = 1;
                        end
                    end
                    1: begin
                        if (bus.s_ready && mv[g]) begin
                            rwm     = rrw[g];
                            beats   = int'(rl[g]) + 1;
                            mv[g]   = 1'b0;
                            infl[g] = 1'b1;
                            ph      = 2;
                        end
                    end
                    default: begin
                        if (rwm ? bus.s_rstb : bus.s_wack) begin
                            if (beats == 1) begin
                                ph      = 0;
                                lastr   = g;
                                infl[g] = 1'b0;
                            end else begin
                                beats--;
                            end
                        end
                    end
                endcase
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/mi_arb2.md
Name: mi_arb2

Overview:
- Two-requester arbiter sharing one mi_* memory-interface slave (QPI PSRAM controller) between the cache (requester 0) and a second master, e.g. video/DMA (requester 1).
- Grants one complete transaction at a time: command handshake, then the full data burst.
- Round-robin by default; routes command, write and read channels to the granted requester.

Parameters:
AW, 24, mi address width
LW, 7, mi burst length width

Ports:
clk_4x_s  in  1  clock
rst  in  1  synchronous reset, active-high
m_addr  in  2*AW  per-requester address; requester i at [i*AW+:AW]
m_len  in  2*LW  per-requester burst length
m_rw  in  2  per-requester direction (1 = read)
m_valid  in  2  per-requester command valid
m_ready  out  2  per-requester command accepted
m_wdata  in  64  per-requester write data; requester i at [i*32+:32]
m_wack  out  2  per-requester write-data accept
m_wlast  out  2  per-requester last write beat
m_rdata  out  32  read data, broadcast to both requesters
m_rstb  out  2  per-requester read strobe
m_rlast  out  2  per-requester last read beat
s_addr  out  AW  to slave
s_len  out  LW  to slave
s_rw  out  1  to slave
s_valid  out  1  to slave
s_ready  in  1  from slave
s_wdata  out  32  to slave
s_wack  in  1  from slave
s_wlast  in  1  from slave
s_rdata  in  32  from slave
s_rstb  in  1  from slave
s_rlast  in  1  from slave

Behaviour:
Registers:
- state in {IDLE, CMD, DATA}; gnt (1 bit); last (1 bit); rw_q.

Reset:
- state = IDLE, gnt = 0, last = 1 (requester 0 wins first), rw_q = 0.
- All outputs 0 except m_rdata, which follows s_rdata.
- Reset mid-burst abandons the transaction; no completion strobe is produced afterwards.

IDLE:
- s_valid = 0.
- If m_valid != 0, register gnt and go to CMD on the next edge.
- Only one valid: grant it.
- Both valid: grant !last (round-robin).
- Grant latency is 1 cycle from m_valid.

CMD:
- s_addr/s_len/s_rw mux from requester gnt, combinationally.
- s_valid = m_valid[gnt]; m_ready[gnt] = s_ready; m_ready[!gnt] = 0.
- On s_valid & s_ready: rw_q <= m_rw[gnt], go to DATA.
- If m_valid[gnt] drops before the handshake: return to IDLE, last unchanged.

DATA:
- s_valid = 0; s_wdata = m_wdata[gnt].
- m_wack/m_wlast/m_rstb/m_rlast[gnt] mirror the s_* signals; the non-granted requester's bits are 0.
- Exit on (rw_q & s_rstb & s_rlast) or (!rw_q & s_wack & s_wlast): last <= gnt, go to IDLE.
- The exit beat itself is forwarded normally.
- Strobes arriving in IDLE/CMD are ignored (not forwarded).

Throughput:
- At least one IDLE cycle between transactions.
- A requester never gets two consecutive grants while the other has been waiting.
- The non-granted requester's m_valid is held off (m_ready = 0) and is not lost.

Optional Feature:
- Macro MI_ARB_FIXED_PRIO_EN.
- Defined: on simultaneous requests requester 0 always wins; last is not used for the decision.
- Undefined: round-robin as above.
- All other behaviour is identical.

Test Plan:
- Reset, then m_valid=01 with addr 0x000100, len 7, read; slave ready immediately, returns 8 rstb beats with rlast on the 8th -> gnt=0; s_addr=0x000100; m_rstb[0] pulses 8 times; m_rstb[1] stays 0; state returns to IDLE.
- m_valid=11 held continuously, 4 single-beat reads -> grants alternate 0,1,0,1.
- Same stimulus with MI_ARB_FIXED_PRIO_EN defined -> grants 0,0,0,0.
- Requester 1 write, len 3, 4 beats, s_wack every other cycle -> s_wdata equals m_wdata[63:32] on each wack; exits on the 4th wack with wlast.
- s_ready held low for 5 cycles during CMD -> m_ready stays 0 until s_ready rises; m_ready[1]=0 throughout.
- rst asserted on the 3rd of 8 read beats -> all outputs 0 next cycle; state IDLE; a subsequent request from requester 0 is granted normally.
